// File: rtl/csr_access_unit_if.sv
// Bundles the request, response and CSR-file ports of csr_access_unit.
// slave: the sequencer itself. master: the core / CSR file / bench side.
interface csr_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_val;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_illegal;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport slave (
        input  req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_val, req_rd,
        input  resp_ready, csr_rdata,
        output req_ready, resp_valid, resp_rd, resp_data, resp_illegal,
        output csr_wen, csr_addr, csr_wdata
    );

    modport master (
        output req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_val, req_rd,
        output resp_ready, csr_rdata,
        input  req_ready, resp_valid, resp_rd, resp_data, resp_illegal,
        input  csr_wen, csr_addr, csr_wdata
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: accept one instruction, read the CSR, optionally write the RMW result, respond.
// Latency 2 cycles accept-to-response (3 with a write); resp_ready low stalls in RESP indefinitely.
module csr_access_unit (
    input  logic               clock,
    input  logic               reset,
    csr_access_unit_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [11:0] csr_q, csr_d;
    logic [4:0]  rs1_idx_q, rs1_idx_d;
    logic [31:0] rs1_val_q, rs1_val_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] old_q, old_d;
    logic        illegal_q, illegal_d;
    logic        rst_done_q, rst_done_d;

    logic [31:0] op;
    logic [31:0] new_val;
    logic        do_write;
    logic        illegal;

    // Suppression tests the rs1 index, not its value.
    always_comb begin
        op       = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_val_q;
        do_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        illegal  = (funct3_q[1:0] == 2'b00) || (do_write && (csr_q[11:10] == 2'b11));
        case (funct3_q[1:0])
            2'b10:   new_val = old_q | op;
            2'b11:   new_val = old_q & ~op;
            default: new_val = op;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        csr_d      = csr_q;
        rs1_idx_d  = rs1_idx_q;
        rs1_val_d  = rs1_val_q;
        rd_d       = rd_q;
        old_d      = old_q;
        illegal_d  = illegal_q;
        rst_done_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && rst_done_q) begin
                    funct3_d  = bus.req_funct3;
                    csr_d     = bus.req_csr;
                    rs1_idx_d = bus.req_rs1_idx;
                    rs1_val_d = bus.req_rs1_val;
                    rd_d      = bus.req_rd;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                old_d     = illegal ? 32'd0 : bus.csr_rdata;
                illegal_d = illegal;
                state_d   = (do_write && !illegal) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            default: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            funct3_q   <= 3'd0;
            csr_q      <= 12'd0;
            rs1_idx_q  <= 5'd0;
            rs1_val_q  <= 32'd0;
            rd_q       <= 5'd0;
            old_q      <= 32'd0;
            illegal_q  <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            csr_q      <= csr_d;
            rs1_idx_q  <= rs1_idx_d;
            rs1_val_q  <= rs1_val_d;
            rd_q       <= rd_d;
            old_q      <= old_d;
            illegal_q  <= illegal_d;
            rst_done_q <= rst_done_d;
        end
    end

    // rst_done_q keeps req_ready low through reset and until the first edge after release.
    assign bus.req_ready    = (state_q == ST_IDLE) && rst_done_q;
    assign bus.resp_valid   = (state_q == ST_RESP);
    assign bus.resp_rd      = rd_q;
    assign bus.resp_data    = old_q;
    assign bus.resp_illegal = illegal_q;
    assign bus.csr_wen      = (state_q == ST_WRITE);
    assign bus.csr_addr     = csr_q;
    assign bus.csr_wdata    = (state_q == ST_WRITE) ? new_val : 32'd0;
endmodule

// File: tb/tb_csr_access_unit.sv
// Vector table plus hand-written stall and mid-operation reset sequences for csr_access_unit.
module tb_csr_access_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    csr_access_unit_if bus ();
    csr_access_unit dut (.clock(clock), .reset(reset), .bus(bus));

    logic [31:0] stub_val = 32'd0;
    assign bus.csr_rdata = stub_val;

    int checks = 0;
    int failures = 0;
    int wen_cnt = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [11:0] last_waddr = 12'd0;

    typedef struct {
        logic [2:0]  funct3;
        logic [11:0] csr;
        logic [4:0]  rs1_idx;
        logic [31:0] rs1_val;
        logic [4:0]  rd;
        logic [31:0] stub;
        logic [31:0] exp_data;
        logic        exp_illegal;
        int          exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        illegal;
        int          wen;
        logic [31:0] wdata;
        logic [11:0] addr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    always @(negedge clock) begin
        if (bus.csr_wen) begin
            wen_cnt    = wen_cnt + 1;
            last_wdata = bus.csr_wdata;
            last_waddr = bus.csr_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"},    {31'd0, bus.req_ready},    32'd0);
        chk({tag, " resp_valid"},   {31'd0, bus.resp_valid},   32'd0);
        chk({tag, " resp_data"},    bus.resp_data,             32'd0);
        chk({tag, " resp_rd"},      {27'd0, bus.resp_rd},      32'd0);
        chk({tag, " resp_illegal"}, {31'd0, bus.resp_illegal}, 32'd0);
        chk({tag, " csr_wen"},      {31'd0, bus.csr_wen},      32'd0);
        chk({tag, " csr_addr"},     {20'd0, bus.csr_addr},     32'd0);
        chk({tag, " csr_wdata"},    bus.csr_wdata,             32'd0);
    endtask

    // Drive one request and return once it has been accepted (bounded wait on req_ready).
    task automatic issue(input vec_t v);
        exp_t e;
        int guard;
        @(negedge clock);
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!bus.req_ready) chk("req_ready timeout", 32'd0, 32'd1);
        stub_val        = v.stub;
        wen_cnt         = 0;
        bus.req_valid   = 1'b1;
        bus.req_funct3  = v.funct3;
        bus.req_csr     = v.csr;
        bus.req_rs1_idx = v.rs1_idx;
        bus.req_rs1_val = v.rs1_val;
        bus.req_rd      = v.rd;
        e.rd = v.rd; e.data = v.exp_data; e.illegal = v.exp_illegal;
        e.wen = v.exp_wen; e.wdata = v.exp_wdata; e.addr = v.csr;
        e.lat = (v.exp_wen != 0) ? 3 : 2;
        sb.push_back(e);
        @(posedge clock);
    endtask

    // Count negedges after the accept edge until resp_valid; returns 0 on timeout.
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) chk("resp_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_resp(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " latency"},      lat,                       e.lat);
        chk({tag, " resp_rd"},      {27'd0, bus.resp_rd},      {27'd0, e.rd});
        chk({tag, " resp_data"},    bus.resp_data,             e.data);
        chk({tag, " resp_illegal"}, {31'd0, bus.resp_illegal}, {31'd0, e.illegal});
        chk({tag, " csr_addr"},     {20'd0, bus.csr_addr},     {20'd0, e.addr});
        chk({tag, " wen count"},    wen_cnt,                   e.wen);
        if (e.wen != 0) begin
            chk({tag, " wdata"}, last_wdata,            e.wdata);
            chk({tag, " waddr"}, {20'd0, last_waddr},   {20'd0, e.addr});
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bus.resp_ready = 1'b1;
        issue(v);
        wait_resp(lat);
        compare_resp(tag, lat);
        @(negedge clock);
        chk({tag, " req_ready after handshake"}, {31'd0, bus.req_ready},  32'd1);
        chk({tag, " resp_valid dropped"},        {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held_data;
        logic [4:0]  held_rd;
        bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_csr = 12'd0;
        bus.req_rs1_idx = 5'd0; bus.req_rs1_val = 32'd0; bus.req_rd = 5'd0;
        bus.resp_ready = 1'b1;

        //              f3      csr     idx    rs1_val       rd     stub          data          ill   wen wdata
        vecs[0]  = '{3'b001, 12'hB00, 5'd3,  32'hDEADBEEF, 5'd5,  32'h00000010, 32'h00000010, 1'b0, 1, 32'hDEADBEEF};
        vecs[1]  = '{3'b010, 12'h300, 5'd2,  32'h0000000F, 5'd6,  32'h0000F0F0, 32'h0000F0F0, 1'b0, 1, 32'h0000F0FF};
        vecs[2]  = '{3'b111, 12'h300, 5'h10, 32'h12345678, 5'd7,  32'h0000F0F0, 32'h0000F0F0, 1'b0, 1, 32'h0000F0E0};
        vecs[3]  = '{3'b010, 12'h300, 5'd0,  32'hFFFFFFFF, 5'd8,  32'h0000AAAA, 32'h0000AAAA, 1'b0, 0, 32'h0};
        vecs[4]  = '{3'b010, 12'h300, 5'd7,  32'h00000000, 5'd9,  32'h00000055, 32'h00000055, 1'b0, 1, 32'h00000055};
        vecs[5]  = '{3'b001, 12'hF11, 5'd3,  32'h11111111, 5'd10, 32'h00001234, 32'h00000000, 1'b1, 0, 32'h0};
        vecs[6]  = '{3'b010, 12'hF11, 5'd0,  32'h11111111, 5'd11, 32'h00001234, 32'h00001234, 1'b0, 0, 32'h0};
        vecs[7]  = '{3'b100, 12'h300, 5'd1,  32'h00000001, 5'd12, 32'h00000077, 32'h00000000, 1'b1, 0, 32'h0};
        vecs[8]  = '{3'b101, 12'h340, 5'h1F, 32'hFFFFFFFF, 5'd13, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1, 32'h0000001F};
        vecs[9]  = '{3'b110, 12'hC00, 5'd0,  32'h00000000, 5'd14, 32'h00ABCDEF, 32'h00ABCDEF, 1'b0, 0, 32'h0};
        vecs[10] = '{3'b011, 12'h305, 5'd4,  32'h0000FF00, 5'd15, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1, 32'h000000FF};
        vecs[11] = '{3'b000, 12'h300, 5'd0,  32'h00000000, 5'd16, 32'h00000099, 32'h00000000, 1'b1, 0, 32'h0};
        vecs[12] = '{3'b001, 12'h340, 5'd9,  32'h0BADC0DE, 5'd0,  32'h00000042, 32'h00000042, 1'b0, 1, 32'h0BADC0DE};

        // Reset state.
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);
        chk("req_ready after release", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: stall 10 cycles in RESP.
        bus.resp_ready = 1'b0;
        issue(vecs[0]);
        wait_resp(lat);
        held_data = bus.resp_data;
        held_rd   = bus.resp_rd;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            bus.req_valid = 1'b1;
            chk("stall resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("stall req_ready",  {31'd0, bus.req_ready},  32'd0);
            chk("stall resp_data",  bus.resp_data,           32'h00000010);
            chk("stall resp_rd",    {27'd0, bus.resp_rd},    {27'd0, held_rd});
        end
        bus.req_valid = 1'b0;
        chk("stall held data", held_data, 32'h00000010);
        compare_resp("stall", lat);
        bus.resp_ready = 1'b1;
        @(negedge clock);
        chk("stall release req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("stall release resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("stall single wen",         wen_cnt,                 1);

        // Reset asserted during the READ cycle of a CSRRW.
        issue(vecs[0]);
        void'(sb.pop_back());
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("midreset in READ", {20'd0, bus.csr_addr}, 32'h00000B00);
        reset = 1'b0;
        @(negedge clock);
        chk_reset_outputs("midreset");
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("midreset no wen", wen_cnt, 0);
        chk("midreset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        run_vec(vecs[1], "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencer between the core's decode/execute stage and the CSR register file. Accepts one Zicsr instruction at a time over a valid/ready request port and reads the addressed CSR. It computes the RISC-V read-modify-write result, then issues at most one write strobe to the CSR file. It returns the old CSR value to writeback over a valid/ready response port, with an illegal-instruction flag.

## Interface
- No parameters; XLEN fixed at 32, CSR address 12 bits.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low; asserted when reset==0, sampled on the clock edge.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- req_csr  in  12  CSR address.
- req_rs1_idx  in  5  rs1 index; also the zero-extended uimm for the *I forms.
- req_rs1_val  in  32  rs1 register value.
- req_rd  in  5  destination register index.
- resp_valid  out  1  result present.
- resp_ready  in  1  writeback accepts.
- resp_rd  out  5  latched rd.
- resp_data  out  32  old CSR value; 0 when illegal.
- resp_illegal  out  1  raise illegal-instruction.
- csr_wen  out  1  CSR file write strobe.
- csr_addr  out  12  CSR file address.
- csr_wdata  out  32  CSR file write data.
- csr_rdata  in  32  CSR file combinational read data for csr_addr.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch funct3, csr, rs1_idx, rs1_val and rd, then go to READ.
- READ:
  - csr_addr=latched csr; capture csr_rdata into the old register.
  - Go to WRITE if do_write&&!illegal, else go to RESP.
- WRITE:
  - csr_wen=1 for exactly this cycle; csr_wdata=new value.
  - Go to RESP.
- RESP:
  - resp_valid=1 and outputs held stable until resp_ready=1.
  - Then go to IDLE.
- Operand: op = funct3[2] ? {27'b0, rs1_idx} : rs1_val.
- New value: RW/RWI gives op; RS/RSI gives old|op; RC/RCI gives old & ~op.
- do_write:
  - Always 1 for RW/RWI.
  - For RS/RC/RSI/RCI, do_write = (rs1_idx != 0).
  - The rs1_idx test applies to the index, not the value, so a nonzero index with a zero value still writes.
- Illegal when either condition holds:
  - funct3 is 000 or 100.
  - do_write=1 and csr[11:10]==2'b11 (read-only space).
- Illegal result: no write, resp_data=0, resp_illegal=1, resp_rd still latched.
- rd==0 does not suppress the read or the write.
- csr_addr holds the latched address from READ through RESP, and is 0 after reset until the first accept.

## Timing
- Reset values: req_ready=0 while reset is asserted, 1 in the first cycle after deassertion.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_illegal=0.
  - csr_wen=0, csr_addr=0, csr_wdata=0.
  - State=IDLE.
- Latency, counted from the accept edge to the first cycle resp_valid=1:
  - 2 cycles with no write.
  - 3 cycles with a write.
- The read value is csr_rdata as sampled at the end of READ. A free-running CSR (e.g. the cycle counter) returns its READ-cycle value.
- The write lands at the end of WRITE and takes priority over any CSR-side update in that cycle.
- No overlap: req_ready=0 from READ until the cycle after the response handshake.
- Minimum accept-to-accept spacing is 3 cycles (no write) or 4 cycles (write), with resp_ready held high.
- resp_ready=0 stalls indefinitely in RESP. No further csr_wen occurs and outputs do not change.
- req_valid in any state other than IDLE is ignored.
- Reset mid-operation: on the edge reset is sampled low, the FSM returns to IDLE.
  - csr_wen=0 from the next cycle; a pending write is dropped.
  - resp_valid=0.

## Test plan
- **CSRRW:** stub CSR 0xB00 holds 0x00000010; request funct3=001, csr=0xB00, rs1_idx=3, rs1_val=0xDEADBEEF, rd=5.
  - One csr_wen pulse, addr 0xB00, data 0xDEADBEEF.
  - resp_data=0x10, resp_rd=5, resp_illegal=0, 3 cycles after accept.
- **Set/clear:**
  - Stub 0x0000F0F0, CSRRS with rs1_val=0x0000000F writes 0x0000F0FF.
  - Stub 0x0000F0F0, CSRRCI with uimm=0x10 writes 0x0000F0E0.
  - Both return resp_data=0x0000F0F0.
- **Write suppression:**
  - CSRRS with rs1_idx=0 and rs1_val=0xFFFFFFFF: no csr_wen, response 2 cycles after accept.
  - CSRRS with rs1_idx=7 and rs1_val=0: exactly one csr_wen with the unchanged value.
- **Read-only/illegal:**
  - CSRRW to 0xF11: no csr_wen, resp_illegal=1, resp_data=0.
  - CSRRS to 0xF11 with rs1_idx=0: legal, returns the stub value.
  - funct3=100: resp_illegal=1.
- **Backpressure:** hold resp_ready=0 for 10 cycles.
  - resp_valid stays 1, outputs stable, req_ready=0, a single csr_wen total.
  - Handshake completes on the first cycle resp_ready=1; req_ready=1 the next cycle.
- **Reset mid-op:** assert reset (0) in the READ cycle of a CSRRW.
  - No csr_wen afterwards, resp_valid=0, all outputs at reset values.
  - A new request after deassertion completes normally.
